// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single req/gnt/rvalid memory port between the instruction fetch
// stage (read-only) and the load/store unit.
//
// The arbiter:
//   - picks one requester per cycle and keeps that choice stable until the
//     memory grants, so the memory never sees a request change under it;
//   - keeps the data side from starving fetch: after STARVE_LIMIT
//     consecutive data grants while fetch waits, fetch wins the next pick;
//   - records the issuer of each accepted transaction in an in-order FIFO
//     and steers each response back to that issuer with zero latency;
//   - drops fetch responses that a fetch flush has made stale.
//
// Parameters
//   MAX_OUTSTANDING  granted-but-unanswered transactions allowed (>=1)
//   STARVE_LIMIT     consecutive data grants while fetch waits (>=1)
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   instr_req_i/addr_i/flush_i      fetch request and flush
//   instr_gnt_o/rvalid_o/rdata_o/err_o   fetch handshake and response
//   data_req_i/we_i/be_i/addr_i/wdata_i  LSU request
//   data_gnt_o/rvalid_o/rdata_o/err_o    LSU handshake and response
//   mem_req_o/addr_o/we_o/be_o/wdata_o   memory request
//   mem_gnt_i/rvalid_i/rdata_i/err_i     memory handshake and response
//   protocol_err_o                  sticky: response arrived with nothing
//                                   outstanding
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   input  logic        instr_flush_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        protocol_err_o
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   localparam logic SRC_DATA  = 1'b0;
   localparam logic SRC_INSTR = 1'b1;

   typedef enum logic {
      S_IDLE,
      S_HOLD
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic             r_owner;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [STV_W-1:0] r_starve;
   logic             r_perr;
   logic             r_src  [MAX_OUTSTANDING];
   logic             r_disc [MAX_OUTSTANDING];

   logic w_owner;
   logic w_owner_req;
   logic w_starve_ok;
   logic w_full;
   logic w_fifo_empty;
   logic w_accept;
   logic w_push;
   logic w_pop;
   logic w_head_src;
   logic w_head_disc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_starve_ok  = (r_starve < STV_W'(STARVE_LIMIT));
   assign w_full       = (r_count == CNT_W'(MAX_OUTSTANDING));
   assign w_fifo_empty = (r_count == '0);

   // Owner selection and FSM next state. In HOLD the latched owner is kept
   // even if the other side is requesting; its request may drop (abort).
   always_comb begin
      w_owner     = SRC_DATA;
      w_owner_req = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (data_req_i && w_starve_ok) begin
               w_owner     = SRC_DATA;
               w_owner_req = 1'b1;
            end else if (instr_req_i) begin
               w_owner     = SRC_INSTR;
               w_owner_req = 1'b1;
            end else if (data_req_i) begin
               w_owner     = SRC_DATA;
               w_owner_req = 1'b1;
            end
            if (mem_req_o && !mem_gnt_i) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            w_owner     = r_owner;
            w_owner_req = r_owner ? instr_req_i : data_req_i;
            if (w_accept || !w_owner_req) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A full FIFO stalls the request even when a response pops this cycle.
   assign mem_req_o   = rstn & w_owner_req & ~w_full;
   assign mem_addr_o  = w_owner ? instr_addr_i : data_addr_i;
   assign mem_we_o    = w_owner ? 1'b0 : data_we_i;
   assign mem_be_o    = w_owner ? 4'hF : data_be_i;
   assign mem_wdata_o = w_owner ? 32'h0 : data_wdata_i;

   assign w_accept    = mem_req_o & mem_gnt_i;
   assign instr_gnt_o = w_accept &  w_owner;
   assign data_gnt_o  = w_accept & ~w_owner;

   assign w_push      = w_accept;
   assign w_pop       = rstn & mem_rvalid_i & ~w_fifo_empty;
   assign w_head_src  = r_src[r_rd_ptr];
   assign w_head_disc = r_disc[r_rd_ptr];

   // A flush in the same cycle as the head pops also kills that response.
   assign instr_rvalid_o = w_pop &  w_head_src & ~w_head_disc & ~instr_flush_i;
   assign data_rvalid_o  = w_pop & ~w_head_src;
   assign instr_rdata_o  = mem_rdata_i;
   assign instr_err_o    = mem_err_i;
   assign data_rdata_o   = mem_rdata_i;
   assign data_err_o     = mem_err_i;
   assign protocol_err_o = r_perr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_owner  <= SRC_DATA;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_perr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && w_state_nxt == S_HOLD) r_owner <= w_owner;

         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         // Counts data wins only while fetch is actually waiting.
         if (!instr_req_i) begin
            r_starve <= '0;
         end else if (w_accept) begin
            if (w_owner == SRC_INSTR)  r_starve <= '0;
            else if (w_starve_ok)      r_starve <= r_starve + 1'b1;
         end

         if (mem_rvalid_i && w_fifo_empty) r_perr <= 1'b1;
      end
   end

   // Source-ID storage; only entries between the pointers are meaningful.
   // A flush marks every fetch entry, including one pushed this cycle.
   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (instr_flush_i && r_src[i]) r_disc[i] <= 1'b1;
      end
      if (w_push) begin
         r_src[r_wr_ptr]  <= w_owner;
         r_disc[r_wr_ptr] <= instr_flush_i & w_owner;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int MAXO  = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        instr_req_i, instr_flush_i;
   logic [31:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i, data_wdata_i;
   logic        data_gnt_o, data_rvalid_o, data_err_o;
   logic [31:0] data_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_rdata_i;
   logic        protocol_err_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rstn(rstn),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_flush_i(instr_flush_i),
      .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
      .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
      .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .protocol_err_o(protocol_err_o)
   );

   // Reference model: outstanding transactions as a queue of issuers plus
   // a per-entry stale flag; arbitration from the priority rules.
   bit mq_src[$];   // 1 = fetch, 0 = data
   bit mq_disc[$];
   int m_starve;
   bit m_hold, m_hold_src, m_perr;
   bit e_own, e_req, e_mreq, e_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_check();
      int cnt;
      bit hs, hd, pop, irv, drv;
      if (!rstn) begin
         chk("rst_mem_req", mem_req_o, 0);
         chk("rst_igNT", instr_gnt_o, 0);
         chk("rst_dgnt", data_gnt_o, 0);
         chk("rst_irv", instr_rvalid_o, 0);
         chk("rst_drv", data_rvalid_o, 0);
         chk("rst_perr", protocol_err_o, 0);
         return;
      end
      cnt = mq_src.size();
      e_req = 0; e_own = 0;
      if (m_hold) begin
         e_own = m_hold_src;
         e_req = e_own ? instr_req_i : data_req_i;
      end else if (data_req_i && m_starve < LIMIT) begin
         e_own = 0; e_req = 1;
      end else if (instr_req_i) begin
         e_own = 1; e_req = 1;
      end else if (data_req_i) begin
         e_own = 0; e_req = 1;
      end
      e_mreq = e_req && (cnt < MAXO);
      e_acc  = e_mreq && mem_gnt_i;
      chk("mem_req", mem_req_o, e_mreq);
      chk("instr_gnt", instr_gnt_o, e_acc && e_own);
      chk("data_gnt", data_gnt_o, e_acc && !e_own);
      if (e_mreq) begin
         chk("mem_addr", mem_addr_o, e_own ? instr_addr_i : data_addr_i);
         chk("mem_we", mem_we_o, e_own ? 1'b0 : data_we_i);
         chk("mem_be", mem_be_o, e_own ? 4'hF : data_be_i);
         if (!e_own) chk("mem_wdata", mem_wdata_o, data_wdata_i);
      end
      hs = 0; hd = 0;
      if (cnt > 0) begin hs = mq_src[0]; hd = mq_disc[0]; end
      pop = mem_rvalid_i && cnt > 0;
      irv = pop && hs && !hd && !instr_flush_i;
      drv = pop && !hs;
      chk("instr_rvalid", instr_rvalid_o, irv);
      chk("data_rvalid", data_rvalid_o, drv);
      if (irv) begin
         chk("instr_rdata", instr_rdata_o, mem_rdata_i);
         chk("instr_err", instr_err_o, mem_err_i);
      end
      if (drv) begin
         chk("data_rdata", data_rdata_o, mem_rdata_i);
         chk("data_err", data_err_o, mem_err_i);
      end
      chk("perr", protocol_err_o, m_perr);
   endtask

   task automatic model_update();
      if (!rstn) begin
         mq_src.delete(); mq_disc.delete();
         m_starve = 0; m_hold = 0; m_hold_src = 0; m_perr = 0;
         return;
      end
      if (mem_rvalid_i) begin
         if (mq_src.size() > 0) begin
            void'(mq_src.pop_front());
            void'(mq_disc.pop_front());
         end else m_perr = 1;
      end
      if (instr_flush_i)
         foreach (mq_src[i]) if (mq_src[i]) mq_disc[i] = 1;
      if (e_acc) begin
         mq_src.push_back(e_own);
         mq_disc.push_back(instr_flush_i && e_own);
      end
      if (!instr_req_i) m_starve = 0;
      else if (e_acc && e_own) m_starve = 0;
      else if (e_acc && m_starve < LIMIT) m_starve++;
      if (!m_hold) begin
         if (e_mreq && !mem_gnt_i) begin m_hold = 1; m_hold_src = e_own; end
      end else if (e_acc || !e_req) m_hold = 0;
   endtask

   // Inputs are applied at the falling edge; outputs are compared just
   // before the rising edge, then the model advances.
   task automatic cyc();
      #1;
      model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      instr_req_i = 0; instr_flush_i = 0; instr_addr_i = 32'h0;
      data_req_i = 0; data_we_i = 0; data_be_i = 4'h0;
      data_addr_i = 32'h0; data_wdata_i = 32'h0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 32'h0; mem_err_i = 0;
   endtask

   task automatic drain();
      idle_inputs();
      for (int g = 0; g < 16 && mq_src.size() > 0; g++) begin
         mem_rvalid_i = 1; mem_rdata_i = $urandom;
         cyc();
      end
      idle_inputs();
      cyc();
   endtask

   int pat [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      rstn = 0;
      idle_inputs();
      @(negedge clk);

      // Reset: requests and responses must not leak out while rstn is low.
      data_req_i = 1; instr_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
      cyc();
      cyc();
      idle_inputs();
      rstn = 1;
      cyc();

      // Both requesting, memory always granting: fetch wins every 5th grant.
      for (int k = 0; k < 10; k++) begin
         instr_req_i = 1; instr_addr_i = 32'h1000 + 4 * k;
         data_req_i = 1; data_addr_i = 32'h2000 + 4 * k; data_we_i = k[0];
         data_be_i = 4'h3; data_wdata_i = 32'hA000 + k;
         mem_gnt_i = 1; mem_rvalid_i = (mq_src.size() > 0); mem_rdata_i = $urandom;
         #1;
         chk("starve_igNT_seq", instr_gnt_o, pat[k]);
         chk("starve_dgnt_seq", data_gnt_o, !pat[k]);
         cyc();
      end
      drain();

      // Fetch held for three cycles without grant; data arrives meanwhile.
      instr_req_i = 1; instr_addr_i = 32'h0000_5000;
      data_addr_i = 32'h0000_6000; data_be_i = 4'hC;
      for (int k = 1; k <= 4; k++) begin
         data_req_i = (k >= 2);
         mem_gnt_i  = (k == 4);
         #1;
         chk("hold_addr", mem_addr_o, 32'h0000_5000);
         chk("hold_dgnt", data_gnt_o, 0);
         chk("hold_igNT", instr_gnt_o, (k == 4));
         cyc();
      end
      drain();

      // Two outstanding with no response stalls the port; no lookahead.
      data_req_i = 1; data_addr_i = 32'h40; data_be_i = 4'hF; mem_gnt_i = 1;
      cyc();
      cyc();
      #1;
      chk("stall_req", mem_req_o, 0);
      cyc();
      mem_rvalid_i = 1;
      #1;
      chk("stall_pop_req", mem_req_o, 0);
      cyc();
      mem_rvalid_i = 0;
      #1;
      chk("unstall_req", mem_req_o, 1);
      chk("unstall_dgnt", data_gnt_o, 1);
      cyc();
      drain();

      // In-order routing of three responses.
      instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
      #1; chk("route_i0_addr", mem_addr_o, 32'h100);
      cyc();
      instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h200; data_we_i = 0;
      #1; chk("route_d_addr", mem_addr_o, 32'h200);
      cyc();
      data_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA_0001;
      #1;
      chk("route_A_irv", instr_rvalid_o, 1);
      chk("route_A_data", instr_rdata_o, 32'hAAAA_0001);
      chk("route_A_drv", data_rvalid_o, 0);
      cyc();
      mem_rvalid_i = 0; instr_req_i = 1; instr_addr_i = 32'h104;
      #1; chk("route_i1_gnt", instr_gnt_o, 1);
      cyc();
      instr_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hBBBB_0002;
      #1;
      chk("route_B_drv", data_rvalid_o, 1);
      chk("route_B_data", data_rdata_o, 32'hBBBB_0002);
      chk("route_B_irv", instr_rvalid_o, 0);
      cyc();
      mem_rdata_i = 32'hCCCC_0003;
      #1;
      chk("route_C_irv", instr_rvalid_o, 1);
      chk("route_C_data", instr_rdata_o, 32'hCCCC_0003);
      cyc();
      drain();

      // Flush makes two fetch responses stale; the next fetch is live.
      instr_req_i = 1; instr_addr_i = 32'h180; mem_gnt_i = 1;
      cyc();
      instr_addr_i = 32'h184;
      cyc();
      instr_req_i = 0; instr_flush_i = 1;
      cyc();
      instr_flush_i = 0; mem_rvalid_i = 1;
      #1; chk("flush_rv1", instr_rvalid_o, 0);
      cyc();
      instr_req_i = 1; instr_addr_i = 32'h300;
      #1;
      chk("flush_rv2", instr_rvalid_o, 0);
      chk("flush_new_gnt", instr_gnt_o, 1);
      cyc();
      instr_req_i = 0;
      #1; chk("flush_rv3", instr_rvalid_o, 1);
      cyc();
      drain();

      // Randomized traffic, with a reset asserted in the middle.
      for (int n = 0; n < 1500; n++) begin
         instr_req_i   = ($urandom_range(0, 99) < 60);
         instr_addr_i  = $urandom;
         instr_flush_i = ($urandom_range(0, 99) < 6);
         data_req_i    = ($urandom_range(0, 99) < 55);
         data_we_i     = $urandom_range(0, 1);
         data_be_i     = 4'($urandom);
         data_addr_i   = $urandom;
         data_wdata_i  = $urandom;
         mem_gnt_i     = ($urandom_range(0, 99) < 60);
         mem_rvalid_i  = (mq_src.size() > 0) && ($urandom_range(0, 99) < 50);
         mem_rdata_i   = $urandom;
         mem_err_i     = $urandom_range(0, 1);
         rstn          = !(n >= 700 && n < 703);
         cyc();
      end
      rstn = 1;
      drain();

      // Response with nothing outstanding: ignored, sticky error.
      mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
      #1;
      chk("perr_irv", instr_rvalid_o, 0);
      chk("perr_drv", data_rvalid_o, 0);
      chk("perr_before", protocol_err_o, 0);
      cyc();
      mem_rvalid_i = 0;
      cyc();
      #1; chk("perr_sticky", protocol_err_o, 1);
      rstn = 0;
      #1; chk("perr_cleared", protocol_err_o, 0);
      cyc();
      rstn = 1;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
